// File: rtl/dmem_wbuf_if.sv
// Core data-port and loader-port bundle for dmem_wbuf.
// No ready signals: MemWrite and ld_valid are accepted every cycle; a dropped core store is reported through wbuf_ovf.
interface dmem_wbuf_if #(
  parameter int AW   = 6,
  parameter int WBUF = 4
);
  localparam int CW = $clog2(WBUF) + 1;

  logic          MemWrite;
  logic [31:0]   ALUResult;
  logic [31:0]   WriteData;
  logic [31:0]   ReadData;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ovf_clr;
  logic [CW-1:0] wbuf_count;
  logic          wbuf_ovf;

  modport master (
    output MemWrite, ALUResult, WriteData, ld_valid, ld_addr, ld_data, ovf_clr,
    input  ReadData, wbuf_count, wbuf_ovf
  );

  modport slave (
    input  MemWrite, ALUResult, WriteData, ld_valid, ld_addr, ld_data, ovf_clr,
    output ReadData, wbuf_count, wbuf_ovf
  );
endinterface

// File: rtl/dmem_wbuf.sv
// Word-addressed data memory with a loader-priority write port and an in-order posted write buffer.
// Define DMEM_WBUF_FWD_EN to forward the newest matching buffered store onto ReadData.
module dmem_wbuf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int WBUF  = 4
) (
  input  logic      clk,
  input  logic      reset,
  dmem_wbuf_if.slave bus
);
  localparam int PW = $clog2(WBUF);
  localparam int CW = PW + 1;

  logic [31:0]   mem_q      [DEPTH];
  logic [AW-1:0] buf_addr_q [WBUF];
  logic [31:0]   buf_data_q [WBUF];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [AW-1:0] core_idx;
  logic          empty, full, pop, push, drop;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   rd_data;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{bus.ALUResult[31:AW+2], bus.ALUResult[1:0]};

  always_comb begin
    core_idx  = bus.ALUResult[AW+1:2];
    empty     = (count_q == '0);
    full      = (count_q == CW'(WBUF));
    pop       = !bus.ld_valid && !empty;
    drop      = bus.MemWrite && bus.ld_valid && full;
    // Once anything is queued, later stores must queue behind it to keep program order.
    push      = bus.MemWrite && (bus.ld_valid || !empty) && !drop;
    mem_we    = 1'b0;
    mem_waddr = core_idx;
    mem_wdata = bus.WriteData;
    if (bus.ld_valid) begin
      mem_we    = 1'b1;
      mem_waddr = bus.ld_addr;
      mem_wdata = bus.ld_data;
    end else if (!empty) begin
      mem_we    = 1'b1;
      mem_waddr = buf_addr_q[rd_ptr_q];
      mem_wdata = buf_data_q[rd_ptr_q];
    end else if (bus.MemWrite) begin
      mem_we    = 1'b1;
    end
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    ovf_d    = drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage arrays carry no reset; validity lives entirely in the pointers and count.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (push) begin
      buf_addr_q[wr_ptr_q] <= core_idx;
      buf_data_q[wr_ptr_q] <= bus.WriteData;
    end
  end

`ifdef DMEM_WBUF_FWD_EN
  logic [PW-1:0] slot;
  // Walk oldest to newest so the last hit is the youngest matching store.
  always_comb begin
    rd_data = mem_q[core_idx];
    slot    = '0;
    for (int i = 0; i < WBUF; i++) begin
      slot = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (buf_addr_q[slot] == core_idx)) rd_data = buf_data_q[slot];
    end
  end
`else
  assign rd_data = mem_q[core_idx];
`endif

  assign bus.ReadData   = rd_data;
  assign bus.wbuf_count = count_q;
  assign bus.wbuf_ovf   = ovf_q;
endmodule

// File: tb/tb_dmem_wbuf.sv
// Bench for dmem_wbuf: directed vector table, reset-while-buffered sequence, and random traffic
// checked against a queue-based model of the write buffer and memory.
module tb_dmem_wbuf;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int WBUF  = 4;

  typedef struct {
    logic          ld;
    logic [AW-1:0] la;
    logic [31:0]   ldd;
    logic          mw;
    logic [31:0]   addr;
    logic [31:0]   wd;
    logic          clr;
    logic          chk_rd;
    logic [31:0]   exp_rd;
    int            exp_cnt;
    logic          exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ent_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_wbuf_if #(.AW(AW), .WBUF(WBUF)) bus();
  dmem_wbuf #(.DEPTH(DEPTH), .AW(AW), .WBUF(WBUF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int pass_cnt = 0;
  int total    = 0;

  // reference model
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  ent_t        m_q[$];
  bit          m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [32:0] model_read(input logic [AW-1:0] a);
    logic [32:0] r;
    r = {m_known[a], m_mem[a]};
`ifdef DMEM_WBUF_FWD_EN
    for (int i = 0; i < m_q.size(); i++)
      if (m_q[i].a == a) r = {1'b1, m_q[i].d};
`endif
    return r;
  endfunction

  task automatic mem_wr(input logic [AW-1:0] a, input logic [31:0] d);
    m_mem[a]   = d;
    m_known[a] = 1'b1;
  endtask

  task automatic model_step(input vec_t v);
    bit            was_empty, was_full, dropped;
    logic [AW-1:0] ci;
    ent_t          h;
    was_empty = (m_q.size() == 0);
    was_full  = (m_q.size() == WBUF);
    ci        = v.addr[AW+1:2];
    dropped   = 1'b0;
    if (v.ld) mem_wr(v.la, v.ldd);
    else if (!was_empty) begin
      h = m_q.pop_front();
      mem_wr(h.a, h.d);
    end else if (v.mw) mem_wr(ci, v.wd);
    if (v.mw) begin
      if (v.ld && was_full) dropped = 1'b1;
      else if (v.ld || !was_empty) m_q.push_back(ent_t'({ci, v.wd}));
    end
    if (dropped) m_ovf = 1'b1;
    else if (v.clr) m_ovf = 1'b0;
  endtask

  // driver
  task automatic apply(input vec_t v, input bit use_model, input string tag);
    logic [32:0] r;
    @(negedge clk);
    bus.ld_valid  = v.ld;
    bus.ld_addr   = v.la;
    bus.ld_data   = v.ldd;
    bus.MemWrite  = v.mw;
    bus.ALUResult = v.addr;
    bus.WriteData = v.wd;
    bus.ovf_clr   = v.clr;
    #1;
    if (use_model) begin
      r = model_read(v.addr[AW+1:2]);
      if (r[32]) check({tag, "_rd"}, bus.ReadData, r[31:0]);
    end else if (v.chk_rd) check({tag, "_rd"}, bus.ReadData, v.exp_rd);
    @(posedge clk);
    model_step(v);
    #1;
    if (use_model) begin
      check({tag, "_cnt"}, 32'(bus.wbuf_count), 32'(m_q.size()));
      check({tag, "_ovf"}, 32'(bus.wbuf_ovf), 32'(m_ovf));
    end else begin
      check({tag, "_cnt"}, 32'(bus.wbuf_count), 32'(v.exp_cnt));
      check({tag, "_ovf"}, 32'(bus.wbuf_ovf), 32'(v.exp_ovf));
    end
  endtask

  function automatic vec_t mk(input bit ld, input int la, input logic [31:0] ldd, input bit mw,
                              input logic [31:0] addr, input logic [31:0] wd, input bit clr,
                              input bit chk, input logic [31:0] exp_rd, input int cnt, input bit ovf);
    vec_t v;
    v.ld = ld; v.la = AW'(la); v.ldd = ldd; v.mw = mw; v.addr = addr; v.wd = wd; v.clr = clr;
    v.chk_rd = chk; v.exp_rd = exp_rd; v.exp_cnt = cnt; v.exp_ovf = ovf;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] addr, input int cnt, input bit ovf);
    return mk(0, 0, 0, 0, addr, 0, 0, 0, 0, cnt, ovf);
  endfunction

  function automatic vec_t rd(input logic [31:0] addr, input logic [31:0] exp, input int cnt);
    return mk(0, 0, 0, 0, addr, 0, 0, 1, exp, cnt, 0);
  endfunction

  vec_t tbl[$];
  vec_t v;
  bit   ld_burst;

  initial begin
    reset = 1'b0;
    bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_data = '0; bus.MemWrite = 0;
    bus.ALUResult = '0; bus.WriteData = '0; bus.ovf_clr = 0;
    m_ovf = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_cnt", 32'(bus.wbuf_count), 32'd0);
    check("reset_ovf", 32'(bus.wbuf_ovf), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // direct store then readback
    tbl.push_back(mk(0, 0, 0, 1, 32'h10, 32'h11223344, 0, 0, 0, 0, 0));
    tbl.push_back(rd(32'h10, 32'h11223344, 0));
    // loader busy while the core stores 0xA, 0xB, 0xC
    tbl.push_back(mk(1, 10, 32'hD0, 1, 32'h4, 32'hA, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 10, 32'hD0, 1, 32'h8, 32'hB, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 10, 32'hD0, 1, 32'h4, 32'hC, 0, 0, 0, 3, 0));
    tbl.push_back(idle(32'h4, 2, 0));
    tbl.push_back(idle(32'h4, 1, 0));
    tbl.push_back(idle(32'h4, 0, 0));
    tbl.push_back(rd(32'h4, 32'hC, 0));
    tbl.push_back(rd(32'h8, 32'hB, 0));
    tbl.push_back(rd(32'h28, 32'hD0, 0));
    // forwarding: newest buffered store vs stale array word
    tbl.push_back(mk(0, 0, 0, 1, 32'h20, 32'h77, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 11, 32'hE0, 1, 32'h20, 32'h55, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 11, 32'hE0, 1, 32'h20, 32'h66, 0, 0, 0, 2, 0));
`ifdef DMEM_WBUF_FWD_EN
    tbl.push_back(mk(1, 11, 32'hE0, 0, 32'h20, 0, 0, 1, 32'h66, 2, 0));
`else
    tbl.push_back(mk(1, 11, 32'hE0, 0, 32'h20, 0, 0, 1, 32'h77, 2, 0));
`endif
    tbl.push_back(idle(32'h20, 1, 0));
    tbl.push_back(idle(32'h20, 0, 0));
    tbl.push_back(rd(32'h20, 32'h66, 0));
    // overflow: six stores while the loader holds the port
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(1, 12, 32'hE1, 1, 32'h40 + 32'(4 * k), 32'h100 + 32'(k), 0, 0, 0,
                       (k < 4) ? k + 1 : 4, k >= 4));
    tbl.push_back(mk(0, 0, 0, 0, 32'h40, 0, 1, 0, 0, 3, 0));
    tbl.push_back(idle(32'h40, 2, 0));
    tbl.push_back(idle(32'h40, 1, 0));
    tbl.push_back(idle(32'h40, 0, 0));
    tbl.push_back(rd(32'h40, 32'h100, 0));
    tbl.push_back(rd(32'h4C, 32'h103, 0));
    // full buffer, port free, new store: pop and push in one cycle; 0x100 aliases word 0
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 50, 32'hE2, 1, 32'h60 + 32'(4 * k), 32'h200 + 32'(k), 0, 0, 0, k + 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h100, 32'hABCD, 0, 0, 0, 4, 0));
    tbl.push_back(rd(32'h60, 32'h200, 3));
    tbl.push_back(idle(32'h0, 2, 0));
    tbl.push_back(idle(32'h0, 1, 0));
    tbl.push_back(idle(32'h0, 0, 0));
    tbl.push_back(rd(32'h0, 32'hABCD, 0));
    tbl.push_back(rd(32'h100, 32'hABCD, 0));
    // older buffered store drains over the loader's write to the same word
    tbl.push_back(mk(1, 5, 32'h1111, 1, 32'h14, 32'h2222, 0, 0, 0, 1, 0));
    tbl.push_back(idle(32'h14, 0, 0));
    tbl.push_back(rd(32'h14, 32'h2222, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // reset while three stores are buffered
    apply(mk(0, 0, 0, 1, 32'h78, 32'h30, 0, 0, 0, 0, 0), 1'b1, "pre30");
    apply(mk(0, 0, 0, 1, 32'h7C, 32'h31, 0, 0, 0, 0, 0), 1'b1, "pre31");
    apply(mk(1, 40, 32'hE3, 1, 32'h78, 32'hDEAD0030, 0, 0, 0, 0, 0), 1'b1, "buf0");
    apply(mk(1, 40, 32'hE3, 1, 32'h7C, 32'hDEAD0031, 0, 0, 0, 0, 0), 1'b1, "buf1");
    apply(mk(1, 40, 32'hE3, 1, 32'h78, 32'hDEAD0032, 0, 0, 0, 0, 0), 1'b1, "buf2");
    @(negedge clk);
    bus.ld_valid = 0; bus.MemWrite = 0;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_cnt", 32'(bus.wbuf_count), 32'd0);
    check("async_rst_ovf", 32'(bus.wbuf_ovf), 32'd0);
    m_q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_cnt", 32'(bus.wbuf_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    apply(rd(32'h78, 32'h30, 0), 1'b0, "post_rst30");
    apply(rd(32'h7C, 32'h31, 0), 1'b0, "post_rst31");

    // random traffic against the model
    ld_burst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) ld_burst = ~ld_burst;
      v.ld      = ld_burst;
      v.la      = AW'($urandom_range(0, 15));
      v.ldd     = $urandom();
      v.mw      = ($urandom_range(0, 9) < 6);
      v.addr    = $urandom();
      v.addr[AW+1:2] = AW'($urandom_range(0, 15));
      v.wd      = $urandom();
      v.clr     = ($urandom_range(0, 9) == 0);
      v.chk_rd  = 1'b0;
      v.exp_rd  = '0;
      v.exp_cnt = 0;
      v.exp_ovf = 1'b0;
      apply(v, 1'b1, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/dmem_wbuf.md
# dmem_wbuf

Word-addressed data memory sitting directly downstream of the single-cycle core's data port. It consumes `MemWrite`, `ALUResult` and `WriteData`, and returns `ReadData` in the same cycle. The storage array has one write port, shared between the core and an external loader/debug port. The loader has priority, so core stores arriving while the port is taken are posted into a small in-order write buffer that drains whenever the port is free.

## Interface
Parameters:
- `DEPTH`, default 64: number of 32-bit words in the array.
- `AW`, default 6: word-index width; must satisfy 2^AW = DEPTH.
- `WBUF`, default 4: write-buffer entries; power of two, minimum 2.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. Asserting it (0) immediately clears all control state.
- `MemWrite` in 1: core store strobe.
- `ALUResult` in 32: core byte address. The word index is `ALUResult[AW+1:2]`.
- `WriteData` in 32: core store data.
- `ReadData` out 32: combinational load data.
- `ld_valid` in 1: loader write request. Always accepted in the cycle it is asserted.
- `ld_addr` in AW: loader word index.
- `ld_data` in 32: loader write data.
- `ovf_clr` in 1: synchronous clear of `wbuf_ovf`.
- `wbuf_count` out $clog2(WBUF)+1: current buffer occupancy.
- `wbuf_ovf` out 1: sticky flag, set when a core store was dropped.

## Operation
Address handling:
- Address bits above `AW+1` are ignored, so addresses alias modulo DEPTH words.
- Address bits `[1:0]` are ignored.
- Stores always write full words.

Write-port priority each cycle (exactly one array write at most):
1. `ld_valid`=1: `ld_data` is written to `ld_addr`.
2. Otherwise, buffer non-empty: the head entry is written and popped.
3. Otherwise, `MemWrite`=1 with buffer empty: direct write to the array. No buffer entry is created.

Core store handling when `MemWrite`=1:
- Enqueued if the buffer is non-empty, to preserve order.
- Enqueued if `ld_valid`=1.
- Dropped if the buffer is full and `ld_valid`=1. `wbuf_ovf` is then set on the next edge.

Simultaneous events:
- A pop and a push in the same cycle leave `wbuf_count` unchanged.
- When the buffer is full and `ld_valid`=0, the pop frees a slot and the store is accepted.

Ordering rule:
- A loader write to word X, followed later by the drain of an older buffered store to X, ends with the buffered data in X.
- This is intended behaviour and must not be "fixed".

Reads:
- `ReadData` is the array word at the current index. See Configuration for forwarding from the buffer.
- A write committed on edge N is visible through `ReadData` from cycle N+1 onward.

`wbuf_ovf`:
- Set by a dropped store.
- Cleared by `ovf_clr`=1 or by reset.
- When a drop and `ovf_clr` occur in the same cycle, set wins.

## Timing
- Reset values: `wbuf_count`=0, `wbuf_ovf`=0, buffer read/write pointers=0.
- Array contents are not reset and read back X until written.
- `ReadData` during reset is array data (forwarding inactive, since the buffer is empty).
- Store latency:
  - Direct write: commits on the same edge.
  - Buffered write: drains on the first edge with `ld_valid`=0 after all older entries have drained.
- Reset asserted mid-drain: all buffered stores are discarded and pointers return to 0. Array words already written keep their values.
- Release is asynchronous; the first update occurs on the first `clk` edge with `reset`=1.
- Buffer pointers wrap modulo WBUF. Full is detected when `count == WBUF`, not by pointer equality alone.

## Configuration
- `DMEM_WBUF_FWD_EN` defined:
  - `ReadData` checks all valid buffer entries for an index match and returns the newest match.
  - With no match, the array word is returned.
  - Loads therefore always see the core's own program-order stores.
- `DMEM_WBUF_FWD_EN` undefined:
  - `ReadData` returns the array word only.
  - A load that hits an undrained buffered store returns stale data.
  - No comparators are built.

## Test plan
- Reset → `wbuf_count`=0, `wbuf_ovf`=0. Then store 0x11223344 at byte address 0x10 with `ld_valid`=0 → next cycle, a load of 0x10 returns 0x11223344 and `wbuf_count` stays 0.
- Hold `ld_valid`=1 for 3 cycles while the core stores 0xA, 0xB, 0xC to byte addresses 0x4, 0x8, 0x4 → `wbuf_count` goes 1, 2, 3.
  - After `ld_valid` drops, the count drains 3→0 over 3 cycles.
  - Final word 1 = 0xC and word 2 = 0xB.
- With `DMEM_WBUF_FWD_EN` defined and the loader busy, store 0x55 then 0x66 to 0x20 → a load of 0x20 returns 0x66 the cycle after the second store.
  - Without the macro, the same load returns the old array value.
- Loader busy 6 cycles with a core store every cycle (WBUF=4) → stores 5 and 6 are dropped, `wbuf_ovf`=1, and 4 words are committed after drain.
  - Then `ovf_clr`=1 → `wbuf_ovf`=0.
- Buffer full and `ld_valid`=0 with `MemWrite`=1 → count remains 4 and the head commits.
  - Byte address 0x100 with DEPTH=64 aliases to word 0.
- Assert `reset`=0 asynchronously with 3 entries buffered → `wbuf_count`=0 immediately (before the next clock edge).
  - The discarded entries never appear in the array.
